// File: rtl/vid_fetch_ctrl_pkg.sv
// Shared definitions for the video fetch sequencer: bus command codes,
// fetch state encoding and the burst-length encoder.
package vid_fetch_ctrl_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_DATA  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_WRESP = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_REQ,
    S_DATA,
    S_NEXT_LINE
  } fetch_state_t;

  // Burst beat count (1,2,4,8) to the 2-bit length code carried on the bus.
  function automatic logic [1:0] len_code(input logic [3:0] beats);
    case (beats)
      4'd8:    return 2'd3;
      4'd4:    return 2'd2;
      4'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vid_fetch_ctrl_if.sv
// Shared-bus signals between the fetch sequencer (master) and the bus fabric.
interface vid_fetch_ctrl_if;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        ackin;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;

  modport master (
    output reqout, reqtar, cmdout, lenout, addrdataout,
    input  ackin, selin, cmdin, lenin, addrdatain
  );

  modport slave (
    input  reqout, reqtar, cmdout, lenout, addrdataout,
    output ackin, selin, cmdin, lenin, addrdatain
  );
endinterface

// File: rtl/vid_fetch_ctrl.sv
// Bus-master fetch sequencer: streams frame scanlines into the pixel FIFO in bursts.
// Optional abort on a stalled bus: define VID_FETCH_TIMEOUT_EN.
module vid_fetch_ctrl
  import vid_fetch_ctrl_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         BURST_LEN  = 4,
  parameter logic [1:0] REQ_PRIO   = 2'b10,
  parameter logic [3:0] MEM_TARGET = 4'h1
`ifdef VID_FETCH_TIMEOUT_EN
  , parameter int       TIMEOUT    = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [31:0]           base_address,
  input  logic [31:0]           lineinc,
  input  logic [11:0]           words_per_line,
  input  logic [11:0]           lines_per_frame,
  vid_fetch_ctrl_if.master      bus,
  input  logic [4:0]            fifo_level,
  output logic                  fifo_wr,
  output logic [31:0]           fifo_wdata,
  output logic                  busy,
  output logic                  fetch_err
);

  fetch_state_t state_q, state_d;

  logic [31:0] line_addr_q, addr_q;
  logic [11:0] words_left_q, lines_left_q;
  logic [3:0]  beats_left_q, burst_beats;
  logic [1:0]  len_q;
  logic        pend_q, err_q;
  logic [5:0]  room;
  logic        beat, last_beat, stray, len_bad, room_ok, load_frame, tmo_hit;

  logic [1:0]  reqout_q, reqout_d;
  logic [3:0]  reqtar_q, reqtar_d;
  logic [2:0]  cmdout_q, cmdout_d;
  logic [1:0]  lenout_q, lenout_d;
  logic [31:0] addr_out_q, addr_out_d;
  logic        fifo_wr_q, fifo_wr_d, busy_q, busy_d;
  logic [31:0] fifo_wdata_q, fifo_wdata_d;

  assign beat        = (state_q == S_DATA) && bus.selin && (bus.cmdin == CMD_DATA);
  assign last_beat   = beat && (beats_left_q == 4'd1);
  // Beats are only legal in DATA; IDLE ignores the bus so beats of an
  // aborted burst drain silently.
  assign stray       = (state_q != S_IDLE) && (state_q != S_DATA) &&
                       bus.selin && (bus.cmdin == CMD_DATA);
  assign len_bad     = beat && (bus.lenin != len_q);
  assign burst_beats = (words_left_q >= 12'(BURST_LEN)) ? 4'(BURST_LEN) : 4'd1;
  assign room        = 6'(FIFO_DEPTH) - {1'b0, fifo_level};
  // fifo_level lags a push by one cycle, so hold off while a push is in flight.
  assign room_ok     = !fifo_wr_q && (room >= {2'b00, burst_beats});

`ifdef VID_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             in_burst, progress;

  assign in_burst = (state_q == S_REQ) || (state_q == S_DATA);
  assign progress = ((state_q == S_REQ) && bus.ackin) || beat;
  assign tmo_hit  = in_burst && !progress && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || !in_burst || progress) tmo_q <= '0;
    else                                tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          state_d    = S_WAIT_ROOM;
          load_frame = 1'b1;
        end
      end
      S_WAIT_ROOM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          load_frame = 1'b1;
        end else if (room_ok) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ackin) state_d = S_DATA;
      end
      S_DATA: begin
        if (last_beat) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (pend_q || frame_start) begin
            state_d    = S_WAIT_ROOM;
            load_frame = 1'b1;
          end else if (words_left_q != 12'd1) begin
            state_d = S_WAIT_ROOM;
          end else begin
            state_d = S_NEXT_LINE;
          end
        end
      end
      S_NEXT_LINE: begin
        if (frame_start && enable) begin
          state_d    = S_WAIT_ROOM;
          load_frame = 1'b1;
        end else if (lines_left_q == 12'd1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_ROOM;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d    = S_IDLE;
      load_frame = 1'b0;
    end
  end

  // ---- address / word / line counters ----
  always_ff @(posedge clk) begin
    if (load_frame) begin
      line_addr_q  <= base_address;
      addr_q       <= base_address;
      words_left_q <= words_per_line;
      lines_left_q <= lines_per_frame;
    end else if (state_q == S_NEXT_LINE) begin
      lines_left_q <= lines_left_q - 12'd1;
      line_addr_q  <= line_addr_q + lineinc;
      addr_q       <= line_addr_q + lineinc;
      words_left_q <= words_per_line;
    end else if (beat) begin
      addr_q       <= addr_q + 32'd4;
      words_left_q <= words_left_q - 12'd1;
      beats_left_q <= beats_left_q - 4'd1;
    end
    if ((state_q == S_WAIT_ROOM) && (state_d == S_REQ)) begin
      beats_left_q <= burst_beats;
      len_q        <= len_code(burst_beats);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (load_frame || (state_d == S_IDLE))
        pend_q <= 1'b0;
      else if (frame_start && ((state_q == S_REQ) || (state_q == S_DATA)))
        pend_q <= 1'b1;

      if (stray || len_bad || tmo_hit) err_q <= 1'b1;
      else if (frame_start)            err_q <= 1'b0;
    end
  end

  // ---- output logic (registered) ----
  always_comb begin
    reqout_d     = '0;
    reqtar_d     = '0;
    cmdout_d     = CMD_IDLE;
    lenout_d     = '0;
    addr_out_d   = '0;
    if (state_d == S_REQ) begin
      reqout_d   = REQ_PRIO;
      reqtar_d   = MEM_TARGET;
      cmdout_d   = CMD_READ;
      lenout_d   = (state_q == S_REQ) ? len_q : len_code(burst_beats);
      addr_out_d = addr_q;
    end
    fifo_wr_d    = beat;
    fifo_wdata_d = beat ? bus.addrdatain : fifo_wdata_q;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reqout_q     <= '0;
      reqtar_q     <= '0;
      cmdout_q     <= '0;
      lenout_q     <= '0;
      addr_out_q   <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      reqout_q     <= reqout_d;
      reqtar_q     <= reqtar_d;
      cmdout_q     <= cmdout_d;
      lenout_q     <= lenout_d;
      addr_out_q   <= addr_out_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.reqout      = reqout_q;
  assign bus.reqtar      = reqtar_q;
  assign bus.cmdout      = cmdout_q;
  assign bus.lenout      = lenout_q;
  assign bus.addrdataout = addr_out_q;
  assign fifo_wr         = fifo_wr_q;
  assign fifo_wdata      = fifo_wdata_q;
  assign busy            = busy_q;
  assign fetch_err       = err_q;

endmodule

// File: tb/tb_vid_fetch_ctrl.sv
// Directed bench for vid_fetch_ctrl: a simple memory responder answers bursts
// (read data = ~address) and each scenario compares against hand-computed values.
module tb_vid_fetch_ctrl;
  import vid_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] base_address = '0;
  logic [31:0] lineinc = '0;
  logic [11:0] words_per_line = '0;
  logic [11:0] lines_per_frame = '0;
  logic [4:0]  fifo_level = '0;
  logic        fifo_wr, busy, fetch_err;
  logic [31:0] fifo_wdata;

  vid_fetch_ctrl_if bus();

  vid_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .frame_start     (frame_start),
    .base_address    (base_address),
    .lineinc         (lineinc),
    .words_per_line  (words_per_line),
    .lines_per_frame (lines_per_frame),
    .bus             (bus.master),
    .fifo_level      (fifo_level),
    .fifo_wr         (fifo_wr),
    .fifo_wdata      (fifo_wdata),
    .busy            (busy),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] req_addr[$];
  logic [1:0]  req_len[$];
  logic [31:0] wr_data[$];

  int          beats_rem = 0, gap_cnt = 0, gap_next = 0, stall_cnt = 0;
  logic [31:0] beat_addr = '0, stall_exp_addr = '0;
  logic [1:0]  cur_len = '0;

  logic [31:0] exp_a[4];
  logic [1:0]  exp_l[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: record FIFO pushes, then act as the memory responder.
  task automatic step();
    @(negedge clk);
    if (fifo_wr) wr_data.push_back(fifo_wdata);
    if (gap_cnt > 0) begin
      gap_cnt--;
      bus.selin = 1'b0;
      bus.cmdin = CMD_IDLE;
    end else if (beats_rem > 0) begin
      bus.selin      = 1'b1;
      bus.cmdin      = CMD_DATA;
      bus.lenin      = cur_len;
      bus.addrdatain = ~beat_addr;
      beat_addr      = beat_addr + 32'd4;
      beats_rem--;
    end else begin
      bus.selin = 1'b0;
      bus.cmdin = CMD_IDLE;
    end
    bus.ackin = 1'b0;
    if (bus.reqout != 2'b00) begin
      if (stall_cnt > 0) begin
        check("stall_reqout", 32'(bus.reqout), 32'h2);
        check("stall_addr", bus.addrdataout, stall_exp_addr);
        stall_cnt--;
      end else begin
        check("reqtar", 32'(bus.reqtar), 32'h1);
        check("cmdout", 32'(bus.cmdout), 32'h3);
        bus.ackin = 1'b1;
        req_addr.push_back(bus.addrdataout);
        req_len.push_back(bus.lenout);
        beats_rem = 1 << bus.lenout;
        beat_addr = bus.addrdataout;
        cur_len   = bus.lenout;
        gap_cnt   = gap_next;
        gap_next  = 0;
      end
    end
  endtask

  task automatic resp_clear();
    beats_rem = 0; gap_cnt = 0; gap_next = 0; stall_cnt = 0;
    req_addr.delete(); req_len.delete(); wr_data.delete();
  endtask

  task automatic setup(input logic [31:0] b, input logic [31:0] inc,
                       input logic [11:0] wpl, input logic [11:0] lpf);
    resp_clear();
    base_address = b; lineinc = inc; words_per_line = wpl; lines_per_frame = lpf;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'h0);
    step();
    step();
  endtask

  task automatic wait_reqs(input int cnt, input int max, input string tag);
    int n = 0;
    while (req_addr.size() < cnt && n < max) begin
      step();
      n++;
    end
    check(tag, req_addr.size(), cnt);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_reqout"}, 32'(bus.reqout), 32'h0);
    check({tag, "_reqtar"}, 32'(bus.reqtar), 32'h0);
    check({tag, "_cmdout"}, 32'(bus.cmdout), 32'h0);
    check({tag, "_lenout"}, 32'(bus.lenout), 32'h0);
    check({tag, "_addr"}, bus.addrdataout, 32'h0);
    check({tag, "_fifo_wr"}, 32'(fifo_wr), 32'h0);
    check({tag, "_wdata"}, fifo_wdata, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(fetch_err), 32'h0);
  endtask

  initial begin
    bus.ackin = 1'b0; bus.selin = 1'b0; bus.cmdin = CMD_IDLE;
    bus.lenin = 2'b00; bus.addrdatain = '0;

    // Reset state
    repeat (3) step();
    check_outputs_zero("rst");
    reset  = 1'b0;
    enable = 1'b1;
    step();

    // 1: two lines of 8 words, bursts of 4
    setup(32'h1000, 32'h100, 12'd8, 12'd2);
    start_frame();
    wait_idle(300, "t1_idle");
    exp_a = '{32'h1000, 32'h1010, 32'h1100, 32'h1110};
    check("t1_nreq", req_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), req_addr[i], exp_a[i]);
      check($sformatf("t1_len%0d", i), 32'(req_len[i]), 32'h2);
    end
    check("t1_nwr", wr_data.size(), 16);
    check("t1_wr0", wr_data[0], 32'hFFFF_EFFF);
    check("t1_wr8", wr_data[8], 32'hFFFF_EEFF);
    check("t1_wr15", wr_data[15], 32'hFFFF_EEE3);
    check("t1_err", 32'(fetch_err), 32'h0);

    // 2: 6 words -> bursts of 4, 1, 1
    setup(32'h1000, 32'h100, 12'd6, 12'd1);
    start_frame();
    wait_idle(300, "t2_idle");
    exp_a = '{32'h1000, 32'h1010, 32'h1014, 32'h0};
    exp_l = '{2'd2, 2'd0, 2'd0, 2'd0};
    check("t2_nreq", req_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_addr%0d", i), req_addr[i], exp_a[i]);
      check($sformatf("t2_len%0d", i), 32'(req_len[i]), 32'(exp_l[i]));
    end
    check("t2_nwr", wr_data.size(), 6);
    check("t2_wr5", wr_data[5], 32'hFFFF_EFEB);

    // 3: FIFO throttling
    setup(32'h2000, 32'h100, 12'd4, 12'd1);
    fifo_level = 5'd13;
    start_frame();
    repeat (6) step();
    check("t3_busy", 32'(busy), 32'h1);
    check("t3_noreq", 32'(bus.reqout), 32'h0);
    check("t3_nreq0", req_addr.size(), 0);
    fifo_level = 5'd12;
    step();
    check("t3_req", 32'(bus.reqout), 32'h2);
    check("t3_nreq1", req_addr.size(), 1);
    wait_idle(100, "t3_idle");
    check("t3_nwr", wr_data.size(), 4);
    fifo_level = 5'd0;

    // 4: grant held off 10 cycles, frame_start during DATA
    setup(32'h1000, 32'h100, 12'd8, 12'd1);
    stall_cnt = 10; stall_exp_addr = 32'h1000; gap_next = 3;
    start_frame();
    wait_reqs(1, 40, "t4_first_ack");
    check("t4_stall_done", stall_cnt, 0);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_idle(300, "t4_idle");
    exp_a = '{32'h1000, 32'h1000, 32'h1010, 32'h0};
    check("t4_nreq", req_addr.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t4_addr%0d", i), req_addr[i], exp_a[i]);
    check("t4_nwr", wr_data.size(), 12);
    check("t4_wr4", wr_data[4], 32'hFFFF_EFFF);

    // 5: address wrap at 2^32
    setup(32'hFFFF_FFF8, 32'h100, 12'd8, 12'd2);
    start_frame();
    wait_idle(300, "t5_idle");
    exp_a = '{32'hFFFF_FFF8, 32'h0000_0008, 32'h0000_00F8, 32'h0000_0108};
    check("t5_nreq", req_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_addr%0d", i), req_addr[i], exp_a[i]);
    check("t5_nwr", wr_data.size(), 16);
    check("t5_wr2", wr_data[2], 32'hFFFF_FFFF);

    // 6: reset in the middle of DATA; late beats ignored
    setup(32'h3000, 32'h100, 12'd4, 12'd1);
    gap_next = 4;
    start_frame();
    wait_reqs(1, 20, "t6_ack");
    step();
    check("t6_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_outputs_zero("t6_rst");
    wr_data.delete();
    repeat (10) step();
    check("t6_nwr", wr_data.size(), 0);
    check("t6_err", 32'(fetch_err), 32'h0);
    check("t6_idle", 32'(busy), 32'h0);

`ifdef VID_FETCH_TIMEOUT_EN
    // 6b: no data after grant -> abort with error
    setup(32'h4000, 32'h100, 12'd4, 12'd1);
    gap_next = 1000;
    start_frame();
    wait_reqs(1, 20, "t6b_ack");
    repeat (60) step();
    check("t6b_busy60", 32'(busy), 32'h1);
    repeat (10) step();
    check("t6b_busy70", 32'(busy), 32'h0);
    check("t6b_err", 32'(fetch_err), 32'h1);
    check("t6b_reqout", 32'(bus.reqout), 32'h0);
    resp_clear();
    start_frame();
    check("t6b_err_clr", 32'(fetch_err), 32'h0);
    wait_idle(100, "t6b_idle");
`endif

    // 7: stray beat, error clear on frame_start, enable drop in WAIT_ROOM
    setup(32'h5000, 32'h100, 12'd4, 12'd1);
    fifo_level = 5'd16;
    start_frame();
    repeat (3) step();
    check("t7_busy", 32'(busy), 32'h1);
    check("t7_err0", 32'(fetch_err), 32'h0);
    bus.selin = 1'b1;
    bus.cmdin = CMD_DATA;
    step();
    check("t7_err_set", 32'(fetch_err), 32'h1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t7_err_clr", 32'(fetch_err), 32'h0);
    check("t7_busy2", 32'(busy), 32'h1);
    enable = 1'b0;
    step();
    check("t7_dis", 32'(busy), 32'h0);
    check("t7_nreq", req_addr.size(), 0);
    fifo_level = 5'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
